// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed 8-digit hex display scanner with tear-free frame updates
module sevenseg_scan #(
  parameter int CLK_DIV = 100000,
  parameter bit LZB = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        load,
  input  logic [7:0]  digit_en,
  output logic [3:0]  digit,
  output logic [7:0]  an,
  output logic        frame
);
  localparam int PW = $clog2(CLK_DIV);
  logic [PW-1:0] pc;
  logic [2:0]    idx;
  logic [31:0]   pend, disp, hi;
  logic          tick, bound, blank;
  assign tick  = pc == PW'(CLK_DIV - 1);
  assign bound = tick && idx == 3'd7;
  // prescaler, scan index, pending capture and frame-boundary swap into disp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      idx   <= '0;
      pend  <= '0;
      disp  <= '0;
      frame <= 1'b0;
    end else begin
      pc    <= tick ? '0 : pc + 1'b1;
      idx   <= tick ? idx + 3'd1 : idx;
      pend  <= load ? data : pend;
      disp  <= bound ? (load ? data : pend) : disp;
      frame <= bound;
    end
  end
  // current nibble plus leading-zero blanking decides which anode is pulled low
  always_comb begin
    hi    = disp >> {idx, 2'b00};
    digit = hi[3:0];
    blank = LZB && idx != 3'd0 && hi == 32'd0;
    an    = (digit_en[idx] && !blank) ? ~(8'h01 << idx) : 8'hFF;
  end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: random and directed stimulus against a time-based display model
module tb_sevenseg_scan;
  logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  en = 8'hFF;
  logic [3:0]  digit0, digit1;
  logic [7:0]  an0, an1;
  logic        frame0, frame1;
  int          checks = 0, failures = 0;
  int          t = 0;
  logic [31:0] mpend = '0, mdisp = '0;
  logic        mframe = 1'b0;

  always #5 clk = ~clk;

  sevenseg_scan #(.CLK_DIV(4), .LZB(1'b0)) u0 (.clk(clk), .rst(rst), .data(data), .load(load),
    .digit_en(en), .digit(digit0), .an(an0), .frame(frame0));
  sevenseg_scan #(.CLK_DIV(4), .LZB(1'b1)) u1 (.clk(clk), .rst(rst), .data(data), .load(load),
    .digit_en(en), .digit(digit1), .an(an1), .frame(frame1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_digit();
    int slot = (t / 4) % 8;
    logic [31:0] v = mdisp >> (4 * slot);
    return v[3:0];
  endfunction

  function automatic logic [7:0] exp_an(input bit lzb);
    int slot = (t / 4) % 8;
    bit blank = lzb && slot > 0 && (mdisp >> (4 * slot)) == 32'd0;
    return (en[slot] && !blank) ? ~(8'h01 << slot) : 8'hFF;
  endfunction

  task automatic check_all();
    chk("digit", 32'(digit0), 32'(exp_digit()));
    chk("an", 32'(an0), 32'(exp_an(1'b0)));
    chk("frame", 32'(frame0), 32'(mframe));
    chk("digit_lzb", 32'(digit1), 32'(exp_digit()));
    chk("an_lzb", 32'(an1), 32'(exp_an(1'b1)));
    chk("frame_lzb", 32'(frame1), 32'(mframe));
  endtask

  task automatic clear_model();
    t = 0;
    mpend = '0;
    mdisp = '0;
    mframe = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) clear_model();
    else begin
      bit b = (t % 32) == 31;
      if (b) mdisp = load ? data : mpend;
      if (load) mpend = data;
      mframe = b;
      t++;
    end
    #1 check_all();
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_phase(input int p);
    while (t % 32 != p) cycle();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    clear_model();
    #1 check_all();
    chk("rst_an", 32'(an0), 32'(~en[0] ? 8'hFF : 8'hFE));
    chk("rst_digit", 32'(digit0), 32'h0);
  endtask

  initial begin
    #1 check_all();
    run(2);
    rst = 1'b0;
    run(70);
    wait_phase(10);
    data = 32'h89AB_CDEF; load = 1'b1;
    run(80);
    wait_phase(20);
    data = 32'h0BAD_F00D; load = 1'b1;
    cycle();
    wait_phase(31);
    data = 32'h1234_5678; load = 1'b1;
    cycle();
    chk("bound_frame", 32'(frame0), 32'h1);
    chk("bound_digit", 32'(digit0), 32'h8);
    run(40);
    en = 8'h0F;
    run(40);
    en = 8'hFF;
    wait_phase(5);
    data = 32'h0000_00A0; load = 1'b1;
    run(40);
    data = 32'h0; load = 1'b1;
    run(40);
    data = 32'h5555_5555; load = 1'b1;
    cycle();
    wait_phase(31);
    data = 32'h9999_9999; load = 1'b1;
    cycle();
    wait_phase(18);
    data = 32'h7777_7777; load = 1'b1;
    cycle();
    wait_phase(21);
    async_reset();
    run(2);
    rst = 1'b0;
    run(40);
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom % 8) == 0;
      data = $urandom >> $urandom_range(0, 31);
      if (($urandom % 16) == 0) en = 8'($urandom);
      if (($urandom % 400) == 0) begin
        async_reset();
        cycle();
        rst = 1'b0;
      end else cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000, meaning clk cycles per digit slot; legal range 2..2^20.
REQ-002 The block SHALL have parameter LZB, default 0, meaning leading-zero blanking is enabled when set to 1.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port data  input  32  eight hex nibbles; digit k is data[4k+3:4k].
REQ-006 The block SHALL have port load  input  1  single-cycle strobe that captures data into the pending register.
REQ-007 The block SHALL have port digit_en  input  8  per-digit enable; 0 forces that digit dark.
REQ-008 The block SHALL have port digit  output  4  nibble of the currently scanned digit, driven to the downstream hex-to-segment decoder.
REQ-009 The block SHALL have port an  output  8  anode select, active-low; at most one bit low.
REQ-010 The block SHALL have port frame  output  1  one-cycle pulse marking the wrap of the scan from digit 7 to digit 0.

Function
REQ-011 The block SHALL hold a prescaler count pc that counts 0..CLK_DIV-1 and wraps to 0; tick = (pc == CLK_DIV-1).
REQ-012 The block SHALL hold a 3-bit scan index idx that increments modulo 8 on each tick and is otherwise held.
REQ-013 The block SHALL hold a 32-bit pending register pend that is loaded with data in any cycle with load=1.
REQ-014 The block SHALL hold a 32-bit display register disp that is updated only at a frame boundary, i.e. a cycle with tick=1 and idx=7.
REQ-015 At a frame boundary, disp SHALL take data when load=1 in the same cycle, otherwise pend.
REQ-016 The output frame SHALL be registered and SHALL be 1 for exactly the one cycle following a frame boundary, coincident with idx=0 and the new disp.
REQ-017 The output digit SHALL be combinational from registered state: digit = disp[4*idx+3:4*idx].
REQ-018 With LZB=1, digit idx SHALL be blanked when idx>0 and disp nibbles idx..7 are all zero; digit 0 SHALL never be blanked by LZB.
REQ-019 an[k] SHALL be 0 iff k==idx, digit_en[k]==1, and digit k is not LZB-blanked; otherwise 1.
REQ-020 When the current digit is dark, digit SHALL still carry the nibble value, and darkness SHALL be expressed only on an.
REQ-021 Changes to digit_en SHALL affect an in the same cycle; there is no latching of digit_en.
REQ-022 A load strobe outside a frame boundary SHALL NOT alter disp, digit or an until the next frame boundary (tear-free update).
REQ-023 Back-to-back loads SHALL make the last captured value the one transferred to disp at the next boundary.
REQ-024 A full scan frame SHALL last exactly 8*CLK_DIV cycles.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force pc=0, idx=0, pend=0, disp=0 and frame=0.
REQ-026 While rst=1, outputs SHALL read digit=4'h0 and an={7'h7F, ~digit_en[0]}.
REQ-027 Reset asserted mid-frame SHALL discard pending data, and scanning SHALL restart at digit 0 with a full CLK_DIV slot after rst deasserts.

Verification (CLK_DIV=4)
REQ-028 Reset with digit_en=8'hFF SHALL give an=8'hFE and digit=0, and an SHALL step FE,FD,FB,...,7F, changing every 4 cycles, with frame pulsing once per 32 cycles.
REQ-029 load with data=32'h89AB_CDEF mid-frame SHALL keep digit at 0 until the next frame pulse, after which digit SHALL read F,E,D,C,B,A,9,8 across the slots.
REQ-030 load in the exact frame-boundary cycle with data=32'h1234_5678 SHALL make digit=8 in the cycle frame=1, with no old-value frame shown.
REQ-031 digit_en=8'h0F SHALL hold an=8'hFF during slots 4-7 while idx and frame continue normally.
REQ-032 With LZB=1 and disp=32'h0000_00A0, an SHALL be low only in slots 0 and 1; with disp=0, an SHALL be low only in slot 0.
REQ-033 Asserting rst mid-slot 5 after a pending load SHALL give an=8'hFE and digit=0 immediately (asynchronously), and no pending value SHALL appear after release.
